// File: rtl/engine_pkg.sv
// Shared definitions for engine_tiled: operation codes, sequencer states and
// the helper that maps an operation onto the number of active accumulator lanes.
package engine_pkg;

  typedef enum logic [2:0] {
    OP_CONV  = 3'd1,
    OP_MPOOL = 3'd4,
    OP_APOOL = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  function automatic logic is_pool(input logic [2:0] op);
    return (op == OP_MPOOL) || (op == OP_APOOL);
  endfunction

  // Unknown opcodes fall through to the CONV lane count.
  function automatic int unsigned active_lanes(input logic [2:0] op, input int unsigned lanes);
    return is_pool(op) ? 1 : lanes;
  endfunction

endpackage

// File: rtl/engine_tiled_if.sv
// DMA-side bus of engine_tiled: weight/data read request ports and the result write port.
// The engine drives the master modport, the DMA port adapters the slave modport.
interface engine_tiled_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 16
);

  logic              w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_valid;
  logic [DATA_W-1:0] w_data;

  logic              d_rd_en;
  logic [ADDR_W-1:0] d_rd_addr;
  logic              d_valid;
  logic [DATA_W-1:0] d_data;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  modport master (
    output w_rd_en, w_rd_addr, d_rd_en, d_rd_addr,
    output wr_en, wr_addr, wr_data, wr_valid,
    input  w_valid, w_data, d_valid, d_data, wr_ready
  );

  modport slave (
    input  w_rd_en, w_rd_addr, d_rd_en, d_rd_addr,
    input  wr_en, wr_addr, wr_data, wr_valid,
    output w_valid, w_data, d_valid, d_data, wr_ready
  );

endinterface

// File: rtl/result_serializer.sv
// Snapshots the full lane result vector and drains the first count_i entries,
// one per accepted wr_valid/wr_ready handshake; last_o marks the final acceptance.
module result_serializer #(
  parameter int LANES  = 16,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_i,
  input  logic                    capture_i,
  input  logic [CNT_W-1:0]        count_i,
  input  logic [LANES*DATA_W-1:0] result_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic [DATA_W-1:0]       data_o,
  output logic [CNT_W-1:0]        idx_o,
  output logic                    last_o
);

  logic [LANES*DATA_W-1:0] res_q;
  logic [CNT_W-1:0]        idx_q;
  logic [CNT_W-1:0]        count_q;
  logic                    active_q;
  logic                    accept;

  assign accept  = active_q & ready_i;
  assign last_o  = accept & (idx_q == count_q - CNT_W'(1));
  assign valid_o = active_q;
  assign data_o  = res_q[int'(idx_q)*DATA_W +: DATA_W];
  assign idx_o   = idx_q;

  // Entry index only moves on an accepted beat, so a stalled beat stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q    <= '0;
      idx_q    <= '0;
      count_q  <= '0;
      active_q <= 1'b0;
    end else if (clear_i) begin
      idx_q    <= '0;
      active_q <= 1'b0;
    end else if (capture_i) begin
      res_q    <= result_i;
      count_q  <= count_i;
      idx_q    <= '0;
      active_q <= 1'b1;
    end else if (accept) begin
      if (last_o) begin
        idx_q    <= '0;
        active_q <= 1'b0;
      end else begin
        idx_q <= idx_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/engine_tiled.sv
// engine_tiled: sequences one conv/pool layer over tile_count tiles (load lanes, wait, write out).
// Defining ENGINE_TILED_PERF_EN adds perf_cycles, a saturating count of busy cycles per layer.
module engine_tiled
  import engine_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 30
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [2:0]              op_type,
  input  logic [15:0]             tile_count,
  input  logic [ADDR_W-1:0]       data_addr,
  input  logic [ADDR_W-1:0]       weight_addr,
  input  logic [ADDR_W-1:0]       result_addr,
  input  logic [ADDR_W-1:0]       data_stride,
  engine_tiled_if.master          dma,
  output logic [LANES-1:0]        lane_load,
  output logic [LANES*DATA_W-1:0] lane_weight,
  output logic [DATA_W-1:0]       lane_data,
  input  logic [LANES-1:0]        lane_done,
  input  logic [LANES*DATA_W-1:0] lane_result,
  output logic                    busy,
  output logic                    engine_valid
`ifdef ENGINE_TILED_PERF_EN
  ,
  output logic [31:0]             perf_cycles
`endif
);

  localparam int CNT_W  = $clog2(LANES + 1);
  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_e                  state_q;
  logic [CNT_W-1:0]        a_q;
  logic [CNT_W-1:0]        beat_q;
  logic [LANES-1:0]        mask_q;
  logic [15:0]             tile_q;
  logic [15:0]             tiles_q;
  logic [ADDR_W-1:0]       w_addr_q;
  logic [ADDR_W-1:0]       d_addr_q;
  logic [ADDR_W-1:0]       wr_base_q;
  logic [ADDR_W-1:0]       stride_q;
  logic                    w_en_q;
  logic                    d_en_q;
  logic                    wr_en_q;
  logic                    engine_valid_q;
  logic [LANES-1:0]        lane_load_q;
  logic [LANES*DATA_W-1:0] lane_weight_q;
  logic [DATA_W-1:0]       lane_data_q;

  logic                    lanes_ready;
  logic                    ser_capture;
  logic                    ser_last;
  logic [CNT_W-1:0]        ser_idx;

  assign lanes_ready = (lane_done & mask_q) == mask_q;
  assign ser_capture = (state_q == S_WAIT) && lanes_ready && !abort;

  result_serializer #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_serializer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (abort),
    .capture_i (ser_capture),
    .count_i   (a_q),
    .result_i  (lane_result),
    .ready_i   (dma.wr_ready),
    .valid_o   (dma.wr_valid),
    .data_o    (dma.wr_data),
    .idx_o     (ser_idx),
    .last_o    (ser_last)
  );

  assign dma.w_rd_en   = w_en_q;
  assign dma.d_rd_en   = d_en_q;
  assign dma.w_rd_addr = w_addr_q;
  assign dma.d_rd_addr = d_addr_q;
  assign dma.wr_en     = wr_en_q;
  assign dma.wr_addr   = wr_base_q + ADDR_W'(ser_idx);
  assign lane_load     = lane_load_q;
  assign lane_weight   = lane_weight_q;
  assign lane_data     = lane_data_q;
  assign busy          = (state_q != S_IDLE);
  assign engine_valid  = engine_valid_q;

  // Layer sequencer; abort overrides any transition and clears enables/counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      a_q            <= '0;
      beat_q         <= '0;
      mask_q         <= '0;
      tile_q         <= '0;
      tiles_q        <= '0;
      w_addr_q       <= '0;
      d_addr_q       <= '0;
      wr_base_q      <= '0;
      stride_q       <= '0;
      w_en_q         <= 1'b0;
      d_en_q         <= 1'b0;
      wr_en_q        <= 1'b0;
      engine_valid_q <= 1'b0;
      lane_load_q    <= '0;
      lane_weight_q  <= '0;
      lane_data_q    <= '0;
    end else begin
      lane_load_q    <= '0;
      engine_valid_q <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
        beat_q  <= '0;
        tile_q  <= '0;
        w_en_q  <= 1'b0;
        d_en_q  <= 1'b0;
        wr_en_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              a_q       <= CNT_W'(active_lanes(op_type, LANES));
              mask_q    <= is_pool(op_type) ? LANES'(1) : '1;
              tiles_q   <= (tile_count == 16'd0) ? 16'd1 : tile_count;
              w_addr_q  <= weight_addr;
              d_addr_q  <= data_addr;
              wr_base_q <= result_addr;
              stride_q  <= data_stride;
              tile_q    <= '0;
              beat_q    <= '0;
              w_en_q    <= 1'b1;
              d_en_q    <= 1'b1;
              state_q   <= S_LOAD;
            end
          end
          S_LOAD: begin
            if (dma.d_valid) begin
              lane_data_q <= dma.d_data;
            end
            if (dma.w_valid) begin
              lane_weight_q[int'(beat_q)*DATA_W +: DATA_W] <= dma.w_data;
              lane_load_q[beat_q[LIDX_W-1:0]]              <= 1'b1;
              if (beat_q == a_q - CNT_W'(1)) begin
                beat_q  <= '0;
                w_en_q  <= 1'b0;
                d_en_q  <= 1'b0;
                state_q <= S_WAIT;
              end else begin
                beat_q <= beat_q + CNT_W'(1);
              end
            end
          end
          S_WAIT: begin
            if (lanes_ready) begin
              wr_en_q <= 1'b1;
              state_q <= S_WRITE;
            end
          end
          S_WRITE: begin
            if (ser_last) begin
              wr_en_q <= 1'b0;
              state_q <= S_NEXT;
            end
          end
          S_NEXT: begin
            // Weights are reused for every tile, so only data and result addresses move.
            tile_q    <= tile_q + 16'd1;
            d_addr_q  <= d_addr_q + stride_q;
            wr_base_q <= wr_base_q + ADDR_W'(a_q);
            if (tile_q + 16'd1 == tiles_q) begin
              engine_valid_q <= 1'b1;
              state_q        <= S_DONE;
            end else begin
              w_en_q  <= 1'b1;
              d_en_q  <= 1'b1;
              state_q <= S_LOAD;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef ENGINE_TILED_PERF_EN
  logic [31:0] perf_q;

  // Restarts on an accepted start and freezes once the layer returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (state_q == S_IDLE && start && !abort) begin
      perf_q <= '0;
    end else if (state_q != S_IDLE && perf_q != '1) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule
